// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, clocked frame out, device ACK check.
// Define PS2_TX_GLITCH_FILTER_EN to add a FILTER_LEN-cycle stability filter on the sampled clock line.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(INHIBIT_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_RTS       = 3'd2;
  localparam logic [2:0] S_DATA      = 3'd3;
  localparam logic [2:0] S_PAR       = 3'd4;
  localparam logic [2:0] S_STOP      = 3'd5;
  localparam logic [2:0] S_ACK       = 3'd6;
  localparam logic [2:0] S_WAIT_IDLE = 3'd7;

  logic [1:0] clk_sync_reg;
  logic [1:0] data_sync_reg;
  logic       clk_line;
  logic       data_line;
  logic       clk_prev_reg;
  logic       fall;

  // Idle bus level is high, so synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2_clk_i};
      data_sync_reg <= {data_sync_reg[0], ps2_data_i};
    end
  end

  assign data_line = data_sync_reg[1];

`ifdef PS2_TX_GLITCH_FILTER_EN
  localparam int FLT_W = $clog2(FILTER_LEN + 1);

  logic             clk_filt_reg;
  logic [FLT_W-1:0] filt_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_filt_reg <= 1'b1;
      filt_cnt_reg <= '0;
    end else if (clk_sync_reg[1] == clk_filt_reg) begin
      filt_cnt_reg <= '0;
    end else if (filt_cnt_reg == FLT_W'(FILTER_LEN - 1)) begin
      clk_filt_reg <= clk_sync_reg[1];
      filt_cnt_reg <= '0;
    end else begin
      filt_cnt_reg <= filt_cnt_reg + 1'b1;
    end
  end

  assign clk_line = clk_filt_reg;
`else
  // Filter length has no effect when the filter is not built.
  localparam int unused_filter_len = FILTER_LEN;

  assign clk_line = clk_sync_reg[1];
`endif

  always_ff @(posedge clk) begin
    if (rst) clk_prev_reg <= 1'b1;
    else     clk_prev_reg <= clk_line;
  end

  assign fall = clk_prev_reg & ~clk_line;

  logic [2:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [7:0]       byte_reg;
  logic             parity_reg;
  logic [2:0]       bit_idx_reg;
  logic             clk_oe_reg;
  logic             data_oe_reg;
  logic             done_reg;
  logic             err_reg;
  logic [1:0]       err_code_reg;
  logic             cnt_last;

  assign cnt_last = (cnt_reg == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      byte_reg     <= '0;
      parity_reg   <= 1'b0;
      bit_idx_reg  <= '0;
      clk_oe_reg   <= 1'b0;
      data_oe_reg  <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= 2'b00;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          clk_oe_reg  <= 1'b0;
          data_oe_reg <= 1'b0;
          if (tx_valid) begin
            byte_reg     <= tx_data;
            parity_reg   <= ~^tx_data;
            err_code_reg <= 2'b00;
            cnt_reg      <= INHIBIT_LOAD;
            clk_oe_reg   <= 1'b1;
            state_reg    <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          cnt_reg <= cnt_reg - 1'b1;
          // Start bit goes out one cycle ahead of the clock release.
          if (cnt_reg == CNT_W'(2)) data_oe_reg <= 1'b1;
          if (cnt_last) begin
            clk_oe_reg  <= 1'b0;
            data_oe_reg <= 1'b1;
            cnt_reg     <= TIMEOUT_LOAD;
            bit_idx_reg <= '0;
            state_reg   <= S_RTS;
          end
        end
        default: begin
          if (fall) cnt_reg <= TIMEOUT_LOAD;
          else      cnt_reg <= cnt_reg - 1'b1;

          if (state_reg == S_WAIT_IDLE && clk_line && data_line) begin
            done_reg  <= 1'b1;
            state_reg <= S_IDLE;
          end else if (!fall && cnt_last) begin
            err_reg      <= 1'b1;
            err_code_reg <= 2'b01;
            clk_oe_reg   <= 1'b0;
            data_oe_reg  <= 1'b0;
            state_reg    <= S_IDLE;
          end else if (fall) begin
            case (state_reg)
              S_RTS: state_reg <= S_DATA;
              S_DATA: begin
                data_oe_reg <= ~byte_reg[bit_idx_reg];
                bit_idx_reg <= bit_idx_reg + 1'b1;
                if (bit_idx_reg == 3'd7) state_reg <= S_PAR;
              end
              S_PAR: begin
                data_oe_reg <= ~parity_reg;
                state_reg   <= S_STOP;
              end
              S_STOP: begin
                data_oe_reg <= 1'b0;
                state_reg   <= S_ACK;
              end
              S_ACK: begin
                if (!data_line) begin
                  state_reg <= S_WAIT_IDLE;
                end else begin
                  err_reg      <= 1'b1;
                  err_code_reg <= 2'b10;
                  state_reg    <= S_IDLE;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign tx_ready    = (state_reg == S_IDLE);
  assign busy        = ~tx_ready;
  assign done        = done_reg;
  assign err         = err_reg;
  assign err_code    = err_code_reg;
  assign ps2_clk_oe  = clk_oe_reg;
  assign ps2_data_oe = data_oe_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model on open-drain lines, shortened timing parameters.
module tb_ps2_host_tx;

  localparam int INH  = 100;
  localparam int TMO  = 2000;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, err;
  logic [1:0] err_code;
  logic       ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int n_assert = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [1:0] last_code = 2'b00;

  always #5 clk = ~clk;

  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy),
    .done(done),
    .err(err),
    .err_code(err_code),
    .ps2_clk_i(ps2_clk_i),
    .ps2_data_i(ps2_data_i),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  // Count completion pulses; a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) begin
      err_cnt++;
      last_code = err_code;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue a request and measure the inhibit phase; returns on the first sample with the clock released.
  task automatic start_req(input logic [7:0] d);
    int n;
    logic p1, p2;
    @(negedge clk);
    chk("ready_before_req", tx_ready, 1);
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("clk_oe_after_accept", ps2_clk_oe, 1);
    chk("busy_after_accept", busy, 1);
    n = 0; p1 = 1'b0; p2 = 1'b0;
    while (ps2_clk_oe === 1'b1 && n < INH + 50) begin
      p2 = p1;
      p1 = ps2_data_oe;
      n++;
      @(negedge clk);
    end
    chk("inhibit_len", n, INH);
    chk("start_bit_lead", p1, 1);
    chk("start_bit_not_early", p2, 0);
    $display("req %02h: clock held low %0d cycles", d, n);
  endtask

  task automatic dev_frame(input int n, input int glitch_at, input int inject_at,
                           input bit ack, output logic [10:0] bits);
    bits = '0;
    repeat (30) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      bits[i] = ps2_data_i;
      dev_clk_low = 1'b0;
      if (i == glitch_at) begin
        repeat (10) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (3) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF - 13) @(negedge clk);
      end else if (i == inject_at) begin
        tx_data = 8'hAA;
        tx_valid = 1'b1;
        @(negedge clk);
        chk("ready_while_busy", tx_ready, 0);
        tx_valid = 1'b0;
        repeat (HALF - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    if (n == 11) begin
      dev_data_low = ack;
      repeat (5) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HALF / 2) @(negedge clk);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_ready();
    int c;
    c = 0;
    while (tx_ready !== 1'b1 && c < 5000) begin
      @(negedge clk);
      c++;
    end
    chk("ready_after_xfer", tx_ready, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [10:0] bits;
    int d0, e0, c;

    repeat (5) @(negedge clk);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 0xF4 with ACK: start 0, 00101111, parity 0, stop 1.
    d0 = done_cnt; e0 = err_cnt;
    start_req(8'hF4);
    dev_frame(11, -1, -1, 1'b1, bits);
    wait_ready();
    chk("f4_bits", bits, 11'h5E8);
    chk("f4_done", done_cnt - d0, 1);
    chk("f4_err", err_cnt - e0, 0);
    $display("xfer F4: bits %03h done %0d err %0d", bits, done_cnt - d0, err_cnt - e0);

    // 0xFF without ACK -> NACK.
    d0 = done_cnt; e0 = err_cnt;
    start_req(8'hFF);
    dev_frame(11, -1, -1, 1'b0, bits);
    wait_ready();
    chk("ff_bits", bits, 11'h7FE);
    chk("ff_err", err_cnt - e0, 1);
    chk("ff_code_at_err", last_code, 2'b10);
    chk("ff_code_held", err_code, 2'b10);
    chk("ff_done", done_cnt - d0, 0);
    chk("ff_clk_oe", ps2_clk_oe, 0);
    chk("ff_data_oe", ps2_data_oe, 0);
    $display("xfer FF: bits %03h err %0d code %0b", bits, err_cnt - e0, last_code);

    // Device silent after clock release -> timeout.
    e0 = err_cnt;
    start_req(8'h11);
    c = 0;
    while (err !== 1'b1 && c < TMO + 100) begin
      @(negedge clk);
      c++;
    end
    chk("tmo_cycles", c, TMO);
    chk("tmo_code", err_code, 2'b01);
    chk("tmo_clk_oe", ps2_clk_oe, 0);
    chk("tmo_data_oe", ps2_data_oe, 0);
    wait_ready();
    chk("tmo_err_count", err_cnt - e0, 1);
    $display("xfer 11: timeout after %0d cycles code %0b", c, err_code);

    // Reset in the middle of the data bits, then a clean 0xF3.
    d0 = done_cnt; e0 = err_cnt;
    start_req(8'h5A);
    dev_frame(5, -1, -1, 1'b0, bits);
    chk("mid_data_oe_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_clk_oe", ps2_clk_oe, 0);
    chk("rst_mid_data_oe", ps2_data_oe, 0);
    chk("rst_mid_busy", busy, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_done", done_cnt - d0, 0);
    chk("rst_mid_err", err_cnt - e0, 0);
    $display("reset mid-DATA: busy %0b", busy);
    start_req(8'hF3);
    dev_frame(11, -1, -1, 1'b1, bits);
    wait_ready();
    chk("f3_bits", bits, 11'h7E6);
    chk("f3_done", done_cnt - d0, 1);
    chk("f3_err", err_cnt - e0, 0);
    $display("xfer F3: bits %03h done %0d", bits, done_cnt - d0);

    // Request of 0xAA while busy must be dropped.
    d0 = done_cnt; e0 = err_cnt;
    start_req(8'h5A);
    dev_frame(11, -1, 3, 1'b1, bits);
    wait_ready();
    chk("busy_req_bits", bits, 11'h6B4);
    chk("busy_req_done", done_cnt - d0, 1);
    chk("busy_req_err", err_cnt - e0, 0);
    repeat (50) @(negedge clk);
    chk("no_queued_req", busy, 0);
    $display("xfer 5A with AA pulse: bits %03h done %0d", bits, done_cnt - d0);

    // 3-cycle clock glitch during DATA.
    d0 = done_cnt; e0 = err_cnt;
    start_req(8'h3C);
    dev_frame(11, 3, -1, 1'b1, bits);
    wait_ready();
`ifdef PS2_TX_GLITCH_FILTER_EN
    chk("glitch_bits", bits, 11'h678);
    chk("glitch_done", done_cnt - d0, 1);
    chk("glitch_err", err_cnt - e0, 0);
`else
    chk("glitch_done", done_cnt - d0, 0);
    chk("glitch_err", err_cnt - e0, 1);
    chk("glitch_code", last_code, 2'b10);
`endif
    $display("xfer 3C with glitch: bits %03h done %0d err %0d", bits, done_cnt - d0, err_cnt - e0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 command transmitter on the `clk100MHz` domain, the opposite direction to the PS/2 mouse receive path. It sends one byte to the mouse on a single-word valid/ready request, for example 0xF4 (enable streaming), 0xFF (reset) or 0xF3 (set sample rate). It drives the shared `ps2_clk`/`ps2_data` lines as open-drain enables and reports completion, timeout or missing device acknowledge. While it is busy, the receive path must ignore bus activity, which the `busy` output indicates.

## Interface
Parameters:
- `INHIBIT_CYCLES`, 10000: clock-low inhibit time (100 µs at 100 MHz).
- `TIMEOUT_CYCLES`, 1500000: maximum wait for any expected device event (15 ms).
- `FILTER_LEN`, 8: stable-sample count for the glitch filter (used only with the macro).

Ports (clock and reset first):
- `clk` in 1: system clock, `clk100MHz`. One clock for the whole block.
- `rst` in 1: reset, synchronous and active-high.
- `tx_data` in 8: byte to send.
- `tx_valid` in 1: request; accepted when `tx_valid & tx_ready`.
- `tx_ready` out 1: high only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on successful acknowledged transfer.
- `err` out 1: one-cycle pulse on failure.
- `err_code` out 2: 00 none, 01 timeout, 10 NACK. Valid with `err` and held until the next accept.
- `ps2_clk_i` in 1: raw clock line level (asynchronous).
- `ps2_data_i` in 1: raw data line level (asynchronous).
- `ps2_clk_oe` out 1: 1 pulls the clock line low; 0 releases it.
- `ps2_data_oe` out 1: 1 pulls the data line low; 0 releases it.

Reset values: `tx_ready`=1, `busy`=0, `done`=0, `err`=0, `err_code`=00, `ps2_clk_oe`=0, `ps2_data_oe`=0.

## Operation
Input conditioning:
- `ps2_clk_i` and `ps2_data_i` each pass through a 2-FF synchronizer.
- A falling edge of the clock line (`fall`) is detected on the synchronized (optionally filtered) clock: previous value 1, current value 0.

Frame contents:
- The byte and its odd parity (`~^tx_data`) are latched on accept.
- The frame is: start 0, d0..d7 LSB first, parity, stop 1, then the device drives ACK.

State machine, 8 states:
- **IDLE**: all outputs released. On accept: latch the byte, clear `err_code`, load the counter with `INHIBIT_CYCLES`, go INHIBIT.
- **INHIBIT**: `ps2_clk_oe`=1. In the last counter cycle assert `ps2_data_oe`=1 (start bit), then go RTS.
- **RTS**: `ps2_clk_oe`=0 (clock released), `ps2_data_oe`=1. Bit index = 0. Wait for `fall`, then go DATA.
- **DATA**: on each `fall`, set `ps2_data_oe` = ~bit[index] and increment the index. After the 8th falling edge (d7 driven) go PAR.
- **PAR**: on `fall`, drive ~parity, go STOP.
- **STOP**: on `fall`, set `ps2_data_oe`=0 (stop bit 1), go ACK.
- **ACK**: on `fall`, sample synchronized data. If 0, go WAIT_IDLE. If 1, `err` with code 10, go IDLE.
- **WAIT_IDLE**: when synchronized clock and data are both 1, pulse `done`, go IDLE.

Timeout:
- A down-counter is reloaded with `TIMEOUT_CYCLES` on entry to RTS and on every `fall`. It also runs in WAIT_IDLE.
- If it reaches 0 in RTS, DATA, PAR, STOP, ACK or WAIT_IDLE: `err` with code 01, release both lines, go IDLE.

Other rules:
- `tx_valid` while not ready is ignored; nothing is queued.
- `rst` at any state: both OE outputs drop to 0 at that clock edge and the FSM returns to IDLE; no `done` or `err` is produced.
- A `fall` in IDLE or INHIBIT is ignored.

## Timing
- Accept to `ps2_clk_oe` rising: 1 cycle.
- Clock-low duration: exactly `INHIBIT_CYCLES` cycles.
- `ps2_data_oe` asserts 1 cycle before clock release.
- Line `fall` to `ps2_data_oe` update: 3 cycles (2 sync + 1 edge register), plus `FILTER_LEN` cycles when the glitch filter is enabled. Both are far below the ≥30 µs clock-low phase of a PS/2 device.
- `done` or `err` to `tx_ready`=1: same cycle (FSM is already in IDLE).
- Back-to-back requests: a new accept is possible on the cycle after `done`.

## Configuration
- `PS2_TX_GLITCH_FILTER_EN` defined: the synchronized clock feeds a filter that updates its output only after the input has been stable for `FILTER_LEN` consecutive cycles. Pulses shorter than `FILTER_LEN` cycles produce no `fall`.
- Undefined: the 2-FF synchronizer output drives edge detection directly, with no filter logic or latency.

## Test plan
- Send 0xF4 to a device model with a 40 µs clock half-period. Required:
  - clock held low for 10000 cycles;
  - data bits observed by the device on rising edges are 0,0,0,1,0,1,1,1,1, parity 0, stop 1;
  - device ACKs; one `done` pulse; `err` stays 0.
- Send 0xFF; the device model does not drive ACK. Required: `err` pulse with `err_code`=10, lines released, `tx_ready`=1.
- Device never clocks after RTS. Required: `err` with code 01 exactly 1500000 cycles after clock release; both OE outputs 0.
- Assert `rst` mid-DATA after 4 bits. Required: both OE outputs 0 on the next edge, `busy`=0, no `done`/`err`. A following 0xF3 request transfers correctly.
- Pulse `tx_valid` with 0xAA while busy. Required: ignored; the original byte completes unchanged.
- With `PS2_TX_GLITCH_FILTER_EN`, inject a 3-cycle low glitch on the clock line during DATA. Required: bit index unchanged and the transfer completes. Without the macro, the same glitch advances the index (expected; documents the reason for the filter).
